vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
// - VGA 640x480@60 timing master. Drives the xCoord/yCoord pixel coordinates that all overlay
//   renderers (scoreboard, playfield, sprites) consume.
// - Samples their merged 8-bit colour, blanks it outside the visible area, and emits
//   pixel-aligned hsync/vsync/rgb to the board VGA connector.
// - One clk domain. A clock-enable divider derives the pixel rate.
// PARAMETERS
// - CLK_DIV   4    clk cycles per pixel (100 MHz -> 25 MHz); legal range >= 2
// - H_VISIBLE 640  visible pixels per line
// - H_FP      16   horizontal front porch (pixels)
// - H_SYNC    96   hsync pulse width (pixels)
// - H_BP      48   horizontal back porch (pixels); H_TOTAL = sum of H_* = 800
// - V_VISIBLE 480  visible lines per frame
// - V_FP      10   vertical front porch (lines)
// - V_SYNC    2    vsync pulse width (lines)
// - V_BP      33   vertical back porch (lines); V_TOTAL = sum of V_* = 525
// PORTS
// - clk          in   1   system clock, 100 MHz
// - rst_n        in   1   asynchronous active-low reset
// - pix_rgb_in   in   8   merged renderer colour [B1:0|G2:0|R2:0]; valid 1 clk after coords change
// - xCoord       out  11  current column, 0..H_TOTAL-1
// - yCoord       out  11  current line, 0..V_TOTAL-1
// - pix_en       out  1   1-clk strobe on the last clk of each pixel period
// - visible      out  1   xCoord<H_VISIBLE && yCoord<V_VISIBLE (combinational from counters)
// - frame_start  out  1   1-clk pulse coincident with pix_en when x=0,y=0
// - hsync        out  1   active-low, pixel-aligned with rgb
// - vsync        out  1   active-low, pixel-aligned with rgb
// - rgb          out  8   colour to DAC; 0 while blanked
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - div counter, xCoord and yCoord = 0.
//   - pix_en, frame_start = 0; hsync = vsync = 1; rgb = 0.
//   - Reset mid-frame restarts cleanly at (0,0).
// - Divider: div counts 0..CLK_DIV-1 and wraps. pix_en = (div==CLK_DIV-1).
// - Counters advance only on pix_en. xCoord/yCoord are registers, so they hold CLK_DIV clks per pixel.
//   - x==H_TOTAL-1: x->0 and y increments.
//   - y==V_TOTAL-1 at the same time: y->0.
//   - No other wrap exists. Coordinates are never out of range.
// - Renderers register colour 1 clk after the coords. pix_rgb_in is therefore sampled on pix_en
//   (coords stable >= CLK_DIV-1 clks).
// - On pix_en, output registers load from the pre-increment coordinates:
//   - rgb <= visible ? pix_rgb_in : 0.
//   - hsync <= ~(x >= H_VISIBLE+H_FP && x < H_VISIBLE+H_FP+H_SYNC).
//   - vsync <= ~(y >= V_VISIBLE+V_FP && y < V_VISIBLE+V_FP+V_SYNC).
//   - Net latency: rgb/hsync/vsync lag coordinates by exactly one pixel period (CLK_DIV clks).
// - Outputs change only on the clk after pix_en and are otherwise held.
// - frame_start = pix_en && x==0 && y==0.
// - Widths: all compares are unsigned 11-bit. H_TOTAL and V_TOTAL must be <= 2047.
// CONFIGURATION
// - VGA_BORDER_TEST_EN defined:
//   - On visible pixels with x==0, x==H_VISIBLE-1, y==0 or y==V_VISIBLE-1, rgb loads 8'hFF
//     (white) instead of pix_rgb_in.
//   - Used for monitor alignment.
// - VGA_BORDER_TEST_EN undefined: no override. rgb follows pix_rgb_in exactly as above.
// TESTING
// - Reset: hold rst_n=0 for 10 clks -> x=y=0, hsync=vsync=1, rgb=0, pix_en=0.
// - Release reset -> pix_en every 4th clk.
//   - One line = 3200 clks: x wraps 799->0 and y goes 0->1.
//   - Frame = 525 lines: frame_start period 1,680,000 clks.
// - hsync:
//   - Goes low on the clk after pix_en at x=656, i.e. one pixel after x=656 appears.
//   - Stays low exactly 96 pixels (384 clks).
// - vsync: low for exactly 2 lines, beginning one pixel after (x=0, y=490).
// - Hold pix_rgb_in=8'hC0 -> rgb=8'hC0 one pixel after (x=30, y=10).
//   - rgb=0 one pixel after x=640 and for all y>=480.
//   - With VGA_BORDER_TEST_EN: rgb=8'hFF after (0,10).
// - Pulse rst_n low mid-line at (x=300, y=200) -> async clear.
//   - After release, the next frame_start occurs 4 clks later and timing is identical to a cold start.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 timing master: pixel-rate clock-enable divider, raster counters and pixel-aligned sync/colour outputs.
// Optional macro VGA_BORDER_TEST_EN forces a white one-pixel frame around the visible area for monitor alignment.
module vga_timing_gen #(
   parameter int CLK_DIV   = 4,
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  pix_rgb_in,
   output logic [10:0] xCoord,
   output logic [10:0] yCoord,
   output logic        pix_en,
   output logic        visible,
   output logic        frame_start,
   output logic        hsync,
   output logic        vsync,
   output logic [7:0]  rgb
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam logic [10:0] H_TOTAL_M1   = 11'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [10:0] V_TOTAL_M1   = 11'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [10:0] H_VIS        = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS        = 11'(V_VISIBLE);
   localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FP);
   localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FP);
   localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

   logic [DIV_W-1:0] r_div;
   logic [10:0]      r_x;
   logic [10:0]      r_y;
   logic [7:0]       r_rgb;
   logic             r_hsync;
   logic             r_vsync;

   logic w_pixEn;
   logic w_visible;
   logic w_lineEnd;
   logic w_frameEnd;
   logic w_border;
   logic w_hsyncAct;
   logic w_vsyncAct;

   assign w_pixEn    = (r_div == DIV_LAST);
   assign w_visible  = (r_x < H_VIS) && (r_y < V_VIS);
   assign w_lineEnd  = (r_x == H_TOTAL_M1);
   assign w_frameEnd = (r_y == V_TOTAL_M1);
   assign w_hsyncAct = (r_x >= H_SYNC_START) && (r_x < H_SYNC_END);
   assign w_vsyncAct = (r_y >= V_SYNC_START) && (r_y < V_SYNC_END);

`ifdef VGA_BORDER_TEST_EN
   assign w_border = (r_x == 11'd0) || (r_x == H_VIS - 11'd1) ||
                     (r_y == 11'd0) || (r_y == V_VIS - 11'd1);
`else
   assign w_border = 1'b0;
`endif

   // Clock-enable divider: one pix_en strobe on the last clk of every pixel period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= '0;
      end else if (w_pixEn) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x <= '0;
         r_y <= '0;
      end else if (w_pixEn) begin
         if (w_lineEnd) begin
            r_x <= '0;
            r_y <= w_frameEnd ? 11'd0 : r_y + 11'd1;
         end else begin
            r_x <= r_x + 11'd1;
         end
      end
   end

   // Loaded from the pre-increment coordinates, so sync and colour trail xCoord/yCoord by one pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rgb   <= '0;
         r_hsync <= 1'b1;
         r_vsync <= 1'b1;
      end else if (w_pixEn) begin
         r_rgb   <= !w_visible ? 8'h00 : (w_border ? 8'hFF : pix_rgb_in);
         r_hsync <= ~w_hsyncAct;
         r_vsync <= ~w_vsyncAct;
      end
   end

   assign xCoord      = r_x;
   assign yCoord      = r_y;
   assign pix_en      = w_pixEn;
   assign visible     = w_visible;
   assign frame_start = w_pixEn && (r_x == 11'd0) && (r_y == 11'd0);
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign rgb         = r_rgb;

endmodule
